// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer for the IF stage.
// Issues requests to a variable-latency instruction memory. Drives the PC hold
// (pc_freeze) and delivers instruction/valid to the IF/ID register. Arbitrates
// between memory wait states, ID back-pressure (hazard_stall) and EX branch
// redirects (Br_taken). A redirect always wins over every other condition.
module if_fetch_ctrl #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        Br_taken,
  input  logic [31:0] pc_cur,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_freeze,
  output logic        flush_id,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        timeout_err
);

  // IDLE    : no request outstanding, next cycle issues at pc_cur
  // WAIT    : request outstanding, its data is wanted
  // HOLD    : data captured while ID stalled, parked in the hold buffer
  // DISCARD : request outstanding but made stale by a redirect
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state_reg;
  logic [31:0]      hold_buf_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  // Main sequencer: state plus every registered output toward memory and IF/ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      imem_req     <= 1'b0;
      imem_addr    <= 32'h0;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      hold_buf_reg <= 32'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // On a redirect the PC is loading the target this edge, so the
          // request goes out one cycle later from the updated pc_cur.
          if (!Br_taken) begin
            imem_addr <= pc_cur;
            imem_req  <= 1'b1;
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (Br_taken) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              // Response arrived together with the redirect: simply drop it.
              imem_req  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              // Request cannot be withdrawn; wait it out and discard the data.
              state_reg <= S_DISCARD;
            end
          end else if (imem_ack) begin
            if (!hazard_stall) begin
              // Back-to-back issue keeps a zero-wait memory at one per cycle.
              if_instr  <= imem_rdata;
              if_valid  <= 1'b1;
              imem_addr <= pc_cur + 32'd4;
            end else begin
              hold_buf_reg <= imem_rdata;
              imem_req     <= 1'b0;
              state_reg    <= S_HOLD;
            end
          end else if (!hazard_stall) begin
            // ID consumed what it had and nothing new arrived: bubble.
            if_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (Br_taken) begin
            if_valid  <= 1'b0;
            state_reg <= S_IDLE;
          end else if (!hazard_stall) begin
            if_instr  <= hold_buf_reg;
            if_valid  <= 1'b1;
            imem_addr <= pc_cur + 32'd4;
            imem_req  <= 1'b1;
            state_reg <= S_WAIT;
          end
        end

        S_DISCARD: begin
          // A second redirect here only moves the PC; the stale request is
          // still the one outstanding, so only its ack matters.
          if (imem_ack) begin
            imem_req  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Wait counter and sticky timeout flag; the fetch keeps waiting after timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (wait_cnt_reg == TIMEOUT_CNT) begin
        timeout_err <= 1'b1;
      end
      if (imem_ack) begin
        wait_cnt_reg <= '0;
      end else if (imem_req && (wait_cnt_reg != TIMEOUT_CNT)) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
  end

  // PC hold: released on redirect or when an instruction is accepted this edge.
  always_comb begin
    pc_freeze = 1'b1;
    if (!rst) begin
      pc_freeze = 1'b1;
    end else if (Br_taken) begin
      pc_freeze = 1'b0;
    end else begin
      case (state_reg)
        S_WAIT:  pc_freeze = !(imem_ack && !hazard_stall);
        S_HOLD:  pc_freeze = hazard_stall;
        default: pc_freeze = 1'b1;
      endcase
    end
  end

  assign flush_id = Br_taken & rst;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// behavioural model of the fetch rules.
module tb_if_fetch_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        Br_taken = 1'b0;
  logic [31:0] pc_cur = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        pc_freeze;
  logic        flush_id;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        timeout_err;

  if_fetch_ctrl #(
    .TIMEOUT  (255),
    .CNT_W    (8),
    .NOP_INSTR(32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard_stall(hazard_stall),
    .Br_taken    (Br_taken),
    .pc_cur      (pc_cur),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_freeze   (pc_freeze),
    .flush_id    (flush_id),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit verbose  = 1'b1;

  // Behavioural model: request outstanding, request stale, data parked.
  logic        m_req, m_disc, m_held, m_valid, m_err;
  logic [31:0] m_addr, m_instr, m_buf;
  int          m_wait;
  logic [31:0] pc;          // the IF-stage PC register the sequencer controls
  logic [31:0] br_target;
  logic        fz_s, fl_s;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hE3A01005;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_disc = 0; m_held = 0; m_valid = 0; m_err = 0;
    m_addr = 32'h0; m_instr = 32'h0; m_buf = 32'h0; m_wait = 0; pc = 32'h0;
  endtask

  function automatic logic model_freeze(input logic br, input logic hz, input logic ack);
    if (br) return 1'b0;
    if (m_held) return hz;
    if (!m_req || m_disc) return 1'b1;
    return !(ack && !hz);
  endfunction

  // What one clock edge does, from the fetch rules.
  task automatic model_advance(input logic fz);
    logic br, hz, ack;
    br = Br_taken; hz = hazard_stall; ack = imem_ack;
    if (!fz) pc = br ? br_target : pc + 32'd4;
    if (m_wait == TIMEOUT) m_err = 1'b1;
    if (ack) m_wait = 0;
    else if (m_req && m_wait < TIMEOUT) m_wait++;
    if (m_held) begin
      if (br) begin
        m_held = 0; m_valid = 0;
      end else if (!hz) begin
        m_held = 0; m_instr = m_buf; m_valid = 1; m_addr = pc_cur + 32'd4; m_req = 1;
        if (verbose) $display("deliver (from hold) instr=%h next_addr=%h", m_instr, m_addr);
      end
    end else if (!m_req) begin
      if (!br) begin
        m_addr = pc_cur; m_req = 1;
      end
    end else if (m_disc) begin
      if (ack) begin
        m_disc = 0; m_req = 0;
      end
    end else if (br) begin
      m_valid = 0;
      if (ack) m_req = 0;
      else m_disc = 1;
    end else if (ack && !hz) begin
      m_instr = imem_rdata; m_valid = 1; m_addr = pc_cur + 32'd4;
      if (verbose) $display("deliver instr=%h next_addr=%h", m_instr, m_addr);
    end else if (ack) begin
      m_buf = imem_rdata; m_req = 0; m_held = 1;
    end else if (!hz) begin
      m_valid = 0;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, then advance.
  task automatic cyc(input logic br, input logic hz, input logic ack_en,
                     input logic [31:0] tgt, output logic fz_o, output logic fl_o);
    logic fz;
    Br_taken     = br;
    hazard_stall = hz;
    br_target    = tgt;
    imem_ack     = ack_en & m_req;
    imem_rdata   = imem_ack ? mem_word(m_addr) : ($urandom() | 32'h1);
    pc_cur       = pc;
    fz           = model_freeze(br, hz, imem_ack);
    #1;
    fz_o = pc_freeze;
    fl_o = flush_id;
    chk1("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_addr);
    chk1("if_valid", if_valid, m_valid);
    chk("if_instr", if_instr, m_instr);
    chk1("timeout_err", timeout_err, m_err);
    chk1("pc_freeze", pc_freeze, fz);
    chk1("flush_id", flush_id, br);
    @(posedge clk);
    model_advance(fz);
    @(negedge clk);
  endtask

  // Assert reset asynchronously, check reset values at once, release later.
  task automatic apply_reset(input int n);
    Br_taken = 1'b1; hazard_stall = 1'b0; imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chk1("rst_pc_freeze", pc_freeze, 1'b1);
    chk1("rst_flush_id", flush_id, 1'b0);
    model_reset();
    repeat (n) @(negedge clk);
    Br_taken = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, required finish before that", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    br_target = 32'h0;
    @(negedge clk);
    apply_reset(3);

    // Zero-wait memory, no stalls: addresses 0,4,8,C back to back.
    cyc(0, 0, 1, 0, fz_s, fl_s);
    chk1("zw_req", imem_req, 1'b1);
    chk("zw_addr0", imem_addr, 32'h0);
    cyc(0, 0, 1, 0, fz_s, fl_s);
    chk1("zw_valid", if_valid, 1'b1);
    chk("zw_instr0", if_instr, 32'hC0DE0000);
    chk("zw_addr4", imem_addr, 32'h4);
    cyc(0, 0, 1, 0, fz_s, fl_s);
    cyc(0, 0, 1, 0, fz_s, fl_s);
    chk("zw_addrC", imem_addr, 32'hC);
    chk("zw_instr8", if_instr, 32'hC0DE0008);

    // Two-wait memory: freeze 1,1,0 and valid 0,0,1.
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk1("w2_fz0", fz_s, 1'b1);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk1("w2_fz1", fz_s, 1'b1);
    chk1("w2_valid0", if_valid, 1'b0);
    cyc(0, 0, 1, 0, fz_s, fl_s);
    chk1("w2_fz2", fz_s, 1'b0);
    chk1("w2_valid1", if_valid, 1'b1);
    chk("w2_instr", if_instr, 32'hC0DE000C);
    chk("w2_addr", imem_addr, 32'h10);

    // Redirect to 0x40 while waiting on 0x10 with no ack.
    cyc(1, 0, 0, 32'h40, fz_s, fl_s);
    chk1("br_flush", fl_s, 1'b1);
    chk1("br_fz", fz_s, 1'b0);
    chk("br_addr_held", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk1("disc_fz", fz_s, 1'b1);
    cyc(0, 0, 1, 0, fz_s, fl_s);
    chk1("disc_valid", if_valid, 1'b0);
    chk1("disc_req", imem_req, 1'b0);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk("br_new_addr", imem_addr, 32'h40);
    chk1("br_new_req", imem_req, 1'b1);

    // Ack with hazard_stall held for three cycles.
    cyc(0, 1, 1, 0, fz_s, fl_s);
    chk1("hz_fz", fz_s, 1'b1);
    chk1("hz_req", imem_req, 1'b0);
    chk("hz_instr_kept", if_instr, 32'hC0DE000C);
    cyc(0, 1, 0, 0, fz_s, fl_s);
    cyc(0, 1, 0, 0, fz_s, fl_s);
    chk1("hold_fz", fz_s, 1'b1);
    chk1("hold_req", imem_req, 1'b0);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk1("rel_fz", fz_s, 1'b0);
    chk("rel_instr", if_instr, 32'hE3A01005);
    chk1("rel_valid", if_valid, 1'b1);
    chk("rel_addr", imem_addr, 32'h44);
    chk1("rel_req", imem_req, 1'b1);

    // Reset in the middle of a wait, then first request from address 0.
    apply_reset(2);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk1("post_rst_req", imem_req, 1'b1);

    // Randomized traffic under varying memory latency.
    verbose = 1'b0;
    for (int blk = 0; blk < 15; blk++) begin
      int unsigned ack_pct;
      ack_pct = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 50 : 25);
      for (int i = 0; i < 200; i++) begin
        logic        br, hz, ak;
        logic [31:0] tgt;
        br  = ($urandom_range(0, 9) == 0);
        hz  = ($urandom_range(0, 3) == 0);
        ak  = ($urandom_range(1, 100) <= ack_pct);
        tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
        cyc(br, hz, ak, tgt, fz_s, fl_s);
      end
    end
    verbose = 1'b1;

    // Memory never answers: sticky timeout after the wait count saturates.
    apply_reset(2);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    repeat (255) cyc(0, 0, 0, 0, fz_s, fl_s);
    chk1("to_not_yet", timeout_err, 1'b0);
    cyc(0, 0, 0, 0, fz_s, fl_s);
    chk1("to_set", timeout_err, 1'b1);
    cyc(0, 0, 1, 0, fz_s, fl_s);
    chk1("to_sticky", timeout_err, 1'b1);
    chk1("to_late_valid", if_valid, 1'b1);
    apply_reset(2);
    cyc(0, 0, 0, 0, fz_s, fl_s);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
